// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding the decoder.
//   Owns the fetch PC, issues word requests to instruction memory over a
//   valid/ready channel whose responses return in order, buffers returned
//   instructions with their PCs in a DEPTH-entry FIFO, and presents the FIFO
//   head to the decoder. Execute-stage redirects flush the FIFO and mark every
//   outstanding request as stale. A misaligned redirect target parks the stage
//   in FAULT until reset.
// Ports:
//   clk, rst (async, active low)
//   redirect_valid/redirect_pc            : PC change from execute
//   imem_req_valid/ready/addr             : fetch request channel
//   imem_rsp_valid/data                   : in-order responses, always accepted
//   out_valid/ready/inst/pc               : decoder handshake
//   fetch_fault                           : sticky misaligned-redirect flag
// Optional: define IFU_PERF_EN to add the perf_fetched, perf_dropped and
// perf_stall 64-bit event counters.
module ifu_fetch #(
    parameter int unsigned PC_WIDTH   = 64,
    parameter int unsigned INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(64'h8000_0000),
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic                  fetch_fault
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]           perf_fetched,
    output logic [63:0]           perf_dropped,
    output logic [63:0]           perf_stall
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FAULT = 1'b1;

    logic [0:0]            state, stateNext;
    logic [PC_WIDTH-1:0]   fetchPc, fetchPcNext;
    logic [PC_WIDTH-1:0]   rspPc, rspPcNext;
    logic [CntW-1:0]       count, countNext;
    logic [CntW-1:0]       inflight, inflightNext;
    logic [CntW-1:0]       drop, dropNext;
    logic [PtrW-1:0]       rdPtr, rdPtrNext;
    logic [PtrW-1:0]       wrPtr, wrPtrNext;
    logic                  faultNext;

    logic [INST_WIDTH-1:0] fifoInst [DEPTH];
    logic [PC_WIDTH-1:0]   fifoPc   [DEPTH];

    logic                  reqFire;
    logic                  pushEn;
    logic                  popEn;
    logic [CntW:0]         occupancy;

    // Slots already promised: queued entries plus responses still owed.
    assign occupancy = (CntW+1)'(inflight) + (CntW+1)'(count);

    assign imem_req_valid = rst && (state == RUN) && !redirect_valid &&
                            (occupancy < (CntW+1)'(DEPTH));
    assign imem_req_addr  = fetchPc;
    assign out_valid      = (state == RUN) && (count != '0);
    assign out_inst       = fifoInst[rdPtr];
    assign out_pc         = fifoPc[rdPtr];

    assign reqFire = imem_req_valid && imem_req_ready;
    // A redirect flushes the FIFO, so any same-cycle push or pop is void.
    assign pushEn  = imem_rsp_valid && (drop == '0) && (state == RUN) && !redirect_valid;
    assign popEn   = out_valid && out_ready && !redirect_valid;

    // Next-state and counter update.
    always_comb begin
        stateNext    = state;
        fetchPcNext  = fetchPc;
        rspPcNext    = rspPc;
        rdPtrNext    = rdPtr;
        wrPtrNext    = wrPtr;
        dropNext     = drop;
        faultNext    = fetch_fault;
        inflightNext = inflight + CntW'(reqFire) - CntW'(imem_rsp_valid);
        countNext    = count + CntW'(pushEn) - CntW'(popEn);

        if (reqFire) begin
            fetchPcNext = fetchPc + PC_WIDTH'(4);
        end
        if (imem_rsp_valid && (drop != '0)) begin
            dropNext = drop - CntW'(1);
        end
        if (pushEn) begin
            wrPtrNext = wrPtr + PtrW'(1);
            rspPcNext = rspPc + PC_WIDTH'(4);
        end
        if (popEn) begin
            rdPtrNext = rdPtr + PtrW'(1);
        end

        if (redirect_valid) begin
            // Everything still owed after this cycle belongs to the old path.
            countNext   = '0;
            rdPtrNext   = '0;
            wrPtrNext   = '0;
            dropNext    = inflightNext;
            fetchPcNext = redirect_pc;
            rspPcNext   = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                stateNext = FAULT;
                faultNext = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            count       <= '0;
            inflight    <= '0;
            drop        <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= stateNext;
            fetchPc     <= fetchPcNext;
            rspPc       <= rspPcNext;
            count       <= countNext;
            inflight    <= inflightNext;
            drop        <= dropNext;
            rdPtr       <= rdPtrNext;
            wrPtr       <= wrPtrNext;
            fetch_fault <= faultNext;
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoInst[wrPtr] <= imem_rsp_data;
            fifoPc[wrPtr]   <= rspPc;
        end
    end

`ifdef IFU_PERF_EN
    // Event counters; any response that is not pushed counts as dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (pushEn) begin
                perf_fetched <= perf_fetched + 64'(1);
            end
            if (imem_rsp_valid && !pushEn) begin
                perf_dropped <= perf_dropped + 64'(1);
            end
            if (out_ready && !out_valid) begin
                perf_stall <= perf_stall + 64'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch. A behavioural memory
// answers requests in order with random latency; the reference model tracks
// only the architectural PC streams (next request address, next PC the
// decoder must see) and the sticky fault flag.
module tb_ifu_fetch;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        fetch_fault;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_dropped;
    logic [63:0] perf_stall;
`endif

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
`ifdef IFU_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int          testsRun    = 0;
    int          testsFailed = 0;

    logic [63:0] pend[$];     // requests accepted by memory, not yet answered
    logic [63:0] outLog[$];   // PCs delivered to the decoder since reset
    logic [63:0] expReqPc;
    logic [63:0] expOutPc;
    logic        faultModel;
    logic        lastRedir;
    logic        stallHeld;
    logic [63:0] heldAddr;
    logic        lastOutValid;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [63:0] a);
        logic [31:0] x;
        x = a[31:0] ^ a[63:32] ^ 32'h5A3C_96E1;
        return {x[18:0], x[31:19]} ^ 32'h0000_0013;
    endfunction

    // One clock: drive inputs at the falling edge, check what will happen at
    // the next rising edge, update the reference model.
    task automatic step(input logic redir, input logic [63:0] rpc, input logic reqRdy,
                        input logic rspEn, input logic outRdy);
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = reqRdy;
        out_ready      = outRdy;
        if (rspEn && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        lastOutValid = out_valid;
        checkVal("fault_flag", 64'(fetch_fault), 64'(faultModel));
        if (lastRedir) checkVal("outv_after_redir", 64'(out_valid), 64'd0);
        if (redir) checkVal("noreq_on_redir", 64'(imem_req_valid), 64'd0);
        if (faultModel) begin
            checkVal("fault_no_req", 64'(imem_req_valid), 64'd0);
            checkVal("fault_no_out", 64'(out_valid), 64'd0);
        end
        if (stallHeld && !redir && !faultModel) begin
            checkVal("req_hold_valid", 64'(imem_req_valid), 64'd1);
            checkVal("req_hold_addr", imem_req_addr, heldAddr);
        end
        if (imem_req_valid && imem_req_ready) begin
            checkVal("req_addr", imem_req_addr, expReqPc);
            pend.push_back(imem_req_addr);
            expReqPc = expReqPc + 64'd4;
            checkVal("inflight_cap", 64'(pend.size() <= DEPTH), 64'd1);
        end
        if (out_valid && out_ready && !redir && !faultModel) begin
            checkVal("out_pc", out_pc, expOutPc);
            checkVal("out_inst", 64'(out_inst), 64'(memf(expOutPc)));
            outLog.push_back(out_pc);
            expOutPc = expOutPc + 64'd4;
        end
        stallHeld = imem_req_valid && !imem_req_ready && !redir;
        heldAddr  = imem_req_addr;
        if (redir) begin
            expReqPc = rpc;
            expOutPc = rpc;
            if (rpc[1:0] != 2'b00) faultModel = 1'b1;
        end
        lastRedir = redir;
        @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        out_ready      = 1'b0;
        #1;
        checkVal("rst_req_valid", 64'(imem_req_valid), 64'd0);
        checkVal("rst_out_valid", 64'(out_valid), 64'd0);
        checkVal("rst_fault", 64'(fetch_fault), 64'd0);
`ifdef IFU_PERF_EN
        checkVal("rst_perf_fetched", perf_fetched, 64'd0);
`endif
        pend.delete();
        outLog.delete();
        expReqPc   = RESET_PC;
        expOutPc   = RESET_PC;
        faultModel = 1'b0;
        lastRedir  = 1'b0;
        stallHeld  = 1'b0;
        heldAddr   = 64'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int firstOut;
        rst = 1'b0;

        // Streaming with an always-ready memory and decoder.
        doReset();
        firstOut = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
            if (lastOutValid && firstOut < 0) firstOut = i;
        end
        checkVal("first_out_latency", 64'(firstOut >= 0 && firstOut <= 3), 64'd1);
        checkVal("stream_progress", 64'(outLog.size() >= 6), 64'd1);

        // Decoder stalled: FIFO fills, requests stop, nothing lost afterwards.
        doReset();
        for (int i = 0; i < 10; i++) step(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        #2;
        checkVal("full_req_stop", 64'(imem_req_valid), 64'd0);
        checkVal("full_out_valid", 64'(out_valid), 64'd1);
        checkVal("full_none_owed", 64'(pend.size()), 64'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
        checkVal("drain_count", 64'(outLog.size() >= 2), 64'd1);
        if (outLog.size() >= 2) begin
            checkVal("drain_pc0", outLog[0], 64'h8000_0000);
            checkVal("drain_pc1", outLog[1], 64'h8000_0004);
        end

        // Redirect with two requests outstanding.
        doReset();
        for (int i = 0; i < 2; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        checkVal("two_inflight", 64'(pend.size()), 64'd2);
        step(1'b1, 64'h8000_0100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
        checkVal("redir_progress", 64'(outLog.size() >= 1), 64'd1);
        if (outLog.size() >= 1) checkVal("redir_first_pc", outLog[0], 64'h8000_0100);

        // Memory stalls requests for five cycles.
        doReset();
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
            #2;
            checkVal("stall_valid", 64'(imem_req_valid), 64'd1);
            checkVal("stall_addr", imem_req_addr, 64'h8000_0004);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);

        // Misaligned redirect: sticky fault until reset.
        doReset();
        for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 64'h8000_0102, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            step(1'b0, 64'h0, 1'(($urandom) & 1), 1'b1, 1'(($urandom) & 1));
        checkVal("fault_sticky", 64'(fetch_fault), 64'd1);
        checkVal("fault_drained", 64'(pend.size()), 64'd0);

        // PC wrap-around past the top of the address space.
        doReset();
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 64'h0, 1'b1, 1'b1, 1'b1);
        checkVal("wrap_progress", 64'(outLog.size() >= 3), 64'd1);
        if (outLog.size() >= 3) checkVal("wrap_pc2", outLog[2], 64'h0);

`ifdef IFU_PERF_EN
        // One redirect discarding two responses, then five kept fetches.
        doReset();
        for (int i = 0; i < 2; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h8000_0200, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
            step(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        end
        step(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        #2;
        checkVal("perf_dropped", perf_dropped, 64'd2);
        checkVal("perf_fetched", perf_fetched, 64'd5);
`endif

        // Randomized traffic with occasional aligned redirects.
        doReset();
        for (int i = 0; i < 800; i++) begin
            logic        rd;
            logic [63:0] tgt;
            rd  = ($urandom_range(0, 15) == 0);
            tgt = 64'h8000_0000 + 64'({$urandom_range(0, 255), 2'b00});
            step(rd, tgt, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 3) != 0));
        end
        checkVal("random_progress", 64'(outLog.size() >= 50), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage that directly feeds the decoder.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the decoder through a valid/ready handshake.
- Accepts redirects (jal/branch/trap) from execute, discards wrong-path fetches, and flags misaligned targets.

Parameters:
- PC_WIDTH, 64, width of fetch PC and all address ports
- INST_WIDTH, 32, instruction width
- RESET_PC, 64'h8000_0000, fetch PC after reset
- DEPTH, 2, FIFO entries; also caps in-flight requests; power of two, minimum 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  PC_WIDTH  new fetch target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_WIDTH  request address, word aligned
- imem_rsp_valid  in  1  response valid; in order; always accepted
- imem_rsp_data  in  INST_WIDTH  fetched instruction
- out_valid  out  1  instruction available to decoder
- out_ready  in  1  decoder consumes this cycle
- out_inst  out  INST_WIDTH  instruction at FIFO head
- out_pc  out  PC_WIDTH  PC of out_inst
- fetch_fault  out  1  sticky: misaligned redirect target

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; drop=0; state=RUN.
  - Outputs: imem_req_valid=0, out_valid=0, fetch_fault=0.
- States:
  - RUN: normal fetch.
  - FAULT: no requests issued and out_valid=0 until reset.
- Request rules:
  - imem_req_valid = (state==RUN) && !redirect_valid && (inflight + count < DEPTH).
  - imem_req_addr = fetch_pc. Once asserted, valid and addr are held stable until the request is accepted (valid && ready).
  - On acceptance: fetch_pc += 4 (wraps modulo 2^PC_WIDTH); inflight += 1.
- Responses:
  - Each imem_rsp_valid decrements inflight.
  - If drop > 0: the response is discarded and drop decrements.
  - Otherwise: {rsp_data, pc} is pushed to the FIFO. The PC comes from an internal rsp_pc counter, set on redirect and incremented by 4 per kept response.
  - The request gating rule guarantees the FIFO never overflows.
- Output:
  - out_valid = count != 0; out_inst/out_pc = head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged; with an empty FIFO, the entry becomes visible the next cycle (1-cycle response-to-decoder latency).
- Redirect (redirect_valid=1) has priority over all other events in that cycle:
  - FIFO flushed (any simultaneous push or pop ignored).
  - drop = inflight after that cycle's acceptances and responses, i.e., every request still outstanding.
  - fetch_pc = rsp_pc = redirect_pc.
  - No request is issued in the redirect cycle.
  - out_valid=0 on the following cycle.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - state -> FAULT; fetch_fault=1 (sticky).
  - FIFO flushed; outstanding responses still drained and discarded.
- Back-to-back redirects: the later one wins; drop accumulates from inflight correctly.
- Reset mid-operation: all state cleared immediately; responses arriving after reset deassertion for pre-reset requests are not supported (memory is reset with the core).
- Counters are sized $clog2(DEPTH)+1 bits; count and inflight never exceed DEPTH.

Optional Feature:
- Macro IFU_PERF_EN.
- When defined, adds three 64-bit counters, all reset to 0 and readable via ports perf_fetched, perf_dropped, perf_stall:
  - perf_fetched: increments per FIFO push.
  - perf_dropped: increments per discarded response.
  - perf_stall: increments per cycle with out_ready=1 and out_valid=0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, imem always ready, responses 1 cycle after request, out_ready=1:
  - Request addresses 0x80000000, 0x80000004, 0x80000008…
  - out_pc follows the same sequence, out_inst matches memory; first out_valid no later than cycle 3 after reset.
- out_ready=0 for 10 cycles:
  - FIFO fills to DEPTH=2; imem_req_valid drops to 0 with inflight+count=2.
  - On out_ready=1, 0x80000000 then 0x80000004 emerge with no loss.
- Redirect to 0x80000100 with 2 requests in flight:
  - Both stale responses are discarded.
  - Next out_pc=0x80000100; no stale instruction reaches the decoder.
- imem_req_ready=0 for 5 cycles:
  - imem_req_valid stays 1 with imem_req_addr stable at 0x80000004; fetch_pc does not advance.
- Redirect to 0x80000102:
  - fetch_fault=1 next cycle; imem_req_valid and out_valid stay 0; fault persists until rst=0.
- With IFU_PERF_EN, one redirect discarding 2 responses and 5 fetched:
  - perf_dropped=2; perf_fetched=5.
